// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: FSM encoding, reset PC and
// word-alignment mask.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_KILL = 3'd3,
        ST_HOLD = 3'd4
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect arbitration: exception beats decode, target forced to word
// alignment, misalign flagged from the raw target.
module pc_redirect_arb
    import pc_sequencer_pkg::*;
(
    input  logic        id_redir_i,
    input  logic [31:0] id_target_i,
    input  logic        exc_redir_i,
    input  logic [31:0] exc_target_i,
    output logic        redir_o,
    output logic [31:0] target_o,
    output logic        misalign_o
);

    logic [31:0] raw_target;

    assign redir_o    = exc_redir_i | id_redir_i;
    assign raw_target = exc_redir_i ? exc_target_i : id_target_i;
    assign target_o   = raw_target & WORD_ALIGN_MASK;
    assign misalign_o = redir_o & (|raw_target[1:0]);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, single-entry
// fetch buffer, redirect handling with in-flight response kill.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        id_redir,
    input  logic [31:0] id_target,
    input  logic        exc_redir,
    input  logic [31:0] exc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_4,
    output logic        misalign
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fv_q, fv_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] fpc_q, fpc_d;
    logic        misalign_q, misalign_d;
    logic        req_q;

    logic        redir;
    logic [31:0] redir_target;
    logic        redir_misalign;
    logic        load;

    pc_redirect_arb u_arb (
        .id_redir_i   (id_redir),
        .id_target_i  (id_target),
        .exc_redir_i  (exc_redir),
        .exc_target_i (exc_target),
        .redir_o      (redir),
        .target_o     (redir_target),
        .misalign_o   (redir_misalign)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fv_d       = fv_q & stall;   // drained on any non-stalled valid cycle
        instr_d    = instr_q;
        fpc_d      = fpc_q;
        misalign_d = redir_misalign;
        load       = 1'b0;

        case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ: begin
                // Without ready the request stays up; a redirect just swaps the address.
                if (imem_ready) state_d = redir ? ST_KILL : ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (redir) begin
                        state_d = ST_REQ;
                    end else begin
                        load    = 1'b1;
                        state_d = stall ? ST_HOLD : ST_REQ;
                    end
                end else if (redir) begin
                    state_d = ST_KILL;
                end
            end
            ST_KILL: begin
                if (imem_rvalid) state_d = ST_REQ;
            end
            ST_HOLD: begin
                if (!stall || redir) state_d = ST_REQ;
            end
            default: state_d = ST_BOOT;
        endcase

        if (load) begin
            fv_d    = 1'b1;
            instr_d = imem_rdata;
            fpc_d   = pc_q;
            pc_d    = pc_q + 32'd4;
        end
        if (redir) begin
            pc_d = redir_target;
            fv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            fv_q       <= 1'b0;
            instr_q    <= 32'd0;
            fpc_q      <= RESET_PC;
            misalign_q <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fv_q       <= fv_d;
            instr_q    <= instr_d;
            fpc_q      <= fpc_d;
            misalign_q <= misalign_d;
            req_q      <= (state_d == ST_REQ);
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign fetch_valid = fv_q;
    assign fetch_instr = instr_q;
    assign fetch_pc    = fpc_q;
    assign fetch_pc_4  = fpc_q + 32'd4;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, stall hold, redirects,
// alignment, PC wrap and asynchronous reset mid-transaction.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        id_redir;
    logic [31:0] id_target;
    logic        exc_redir;
    logic [31:0] exc_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_4;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .id_redir    (id_redir),
        .id_target   (id_target),
        .exc_redir   (exc_redir),
        .exc_target  (exc_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_pc    (fetch_pc),
        .fetch_pc_4  (fetch_pc_4),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in REQ with stall=0; ends in REQ with the word buffered.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
        chk("req_up", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, addr);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("wait_noreq", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        chk("fv", {31'd0, fetch_valid}, 32'd1);
        chk("fpc", fetch_pc, addr);
        chk("finstr", fetch_instr, data);
        chk("fpc4", fetch_pc_4, addr + 32'd4);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        id_redir = 1'b0; id_target = '0; exc_redir = 1'b0; exc_target = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        step(); step();

        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_fpc", fetch_pc, 32'h0000_3000);
        chk("rst_finstr", fetch_instr, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_3000);

        // Sequential fetch at zero wait
        rst_n = 1'b1;
        step();
        do_fetch(32'h0000_3000, 32'hA000_0000);

        // Buffer 3004 under stall -> HOLD
        chk("a3004", imem_addr, 32'h0000_3004);
        imem_ready = 1'b1;
        step();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hA000_0001; stall = 1'b1;
        step();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_fv", {31'd0, fetch_valid}, 32'd1);
            chk("hold_fpc", fetch_pc, 32'h0000_3004);
            chk("hold_instr", fetch_instr, 32'hA000_0001);
            step();
        end
        stall = 1'b0;
        step();
        chk("drain_fv", {31'd0, fetch_valid}, 32'd0);
        do_fetch(32'h0000_3008, 32'hA000_0002);

        // Redirect in WAIT, response 3 cycles later is killed
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        id_redir = 1'b1; id_target = 32'h0000_4000;
        step();
        id_redir = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("kill_fv", {31'd0, fetch_valid}, 32'd0);
            chk("kill_req", {31'd0, imem_req}, 32'd0);
            step();
        end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("killed_fv", {31'd0, fetch_valid}, 32'd0);
        chk("kill_addr", imem_addr, 32'h0000_4000);
        chk("kill_requp", {31'd0, imem_req}, 32'd1);

        // Misaligned redirect in REQ without ready
        id_redir = 1'b1; id_target = 32'h0000_4102;
        step();
        id_redir = 1'b0;
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_addr", imem_addr, 32'h0000_4100);
        chk("mis_req", {31'd0, imem_req}, 32'd1);
        step();
        chk("mis_clear", {31'd0, misalign}, 32'd0);

        // Exception beats decode, redirect with ready -> KILL
        imem_ready = 1'b1;
        exc_redir = 1'b1; exc_target = 32'h0000_4180;
        id_redir = 1'b1; id_target = 32'h0000_5000;
        step();
        imem_ready = 1'b0; exc_redir = 1'b0; id_redir = 1'b0;
        chk("prio_mis", {31'd0, misalign}, 32'd0);
        chk("prio_noreq", {31'd0, imem_req}, 32'd0);
        chk("prio_pc", imem_addr, 32'h0000_4180);
        imem_rvalid = 1'b1;
        step();
        imem_rvalid = 1'b0;
        chk("prio_fv", {31'd0, fetch_valid}, 32'd0);

        // PC wrap
        id_redir = 1'b1; id_target = 32'hFFFF_FFFC;
        step();
        id_redir = 1'b0;
        do_fetch(32'hFFFF_FFFC, 32'hB000_0000);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Redirect in WAIT together with rvalid: data dropped, straight to REQ
        imem_ready = 1'b1;
        step();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
        id_redir = 1'b1; id_target = 32'h0000_6000;
        step();
        imem_rvalid = 1'b0; id_redir = 1'b0;
        chk("wr_fv", {31'd0, fetch_valid}, 32'd0);
        do_fetch(32'h0000_6000, 32'hC000_0000);

        // Reset mid-WAIT with a live buffer
        stall = 1'b1; imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("pre_fv", {31'd0, fetch_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("mid_rst_fpc", fetch_pc, 32'h0000_3000);
        chk("mid_rst_instr", fetch_instr, 32'd0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0000_3000);
        #2 rst_n = 1'b1;
        stall = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h5A1E_0000;
        step();
        imem_rvalid = 1'b0;
        chk("stale_fv", {31'd0, fetch_valid}, 32'd0);
        do_fetch(32'h0000_3000, 32'hD000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state is updated on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 stall  input  1  decode cannot accept; hold the fetch buffer.
REQ-005 id_redir  input  1  jump/jr/taken-branch redirect from decode.
REQ-006 id_target  input  32  target address for id_redir.
REQ-007 exc_redir  input  1  exception/eret redirect.
REQ-008 exc_target  input  32  target address for exc_redir.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address.
REQ-011 imem_ready  input  1  memory accepts the request this cycle.
REQ-012 imem_rvalid  input  1  read data valid.
REQ-013 imem_rdata  input  32  instruction word.
REQ-014 fetch_valid  output  1  fetch buffer holds a live instruction.
REQ-015 fetch_instr  output  32  buffered instruction.
REQ-016 fetch_pc  output  32  address of fetch_instr.
REQ-017 fetch_pc_4  output  32  fetch_pc + 4, modulo 2^32.
REQ-018 misalign  output  1  one-cycle pulse: accepted redirect target had bits [1:0] != 0.

Function
REQ-019 States: BOOT, REQ, WAIT, KILL, HOLD.
REQ-020 A single outstanding imem request at most.
REQ-021 BOOT: occupies the first cycle after rst_n deasserts; next state REQ; imem_req=0.
REQ-022 REQ: imem_req=1 and imem_addr=pc; on imem_ready, next state WAIT.
REQ-023 WAIT: imem_req=0; on imem_rvalid, load the buffer (fetch_instr=rdata, fetch_pc=pc, fetch_valid=1 next cycle), set pc to pc+4, then go to REQ if the buffer will be free, else HOLD.
REQ-024 Buffer consumption: the buffer is consumed on any cycle with fetch_valid=1 and stall=0; fetch_valid clears unless it is reloaded in the same cycle.
REQ-025 HOLD: entered when the buffer is full and stall=1; no imem_req; on the first cycle with stall=0, next state REQ, which overlaps the next fetch with buffer drain.
REQ-026 Redirect priority: exc_redir over id_redir. Accepted target = target & ~32'h3; misalign pulses if the raw target bits [1:0] != 0.
REQ-027 Redirect effects in every state: pc set to the accepted target; fetch_valid cleared next cycle; a buffer load in the same cycle is discarded.
REQ-028 Redirect in REQ with imem_ready=0: the new address is presented next cycle; the request is never dropped.
REQ-029 Redirect in REQ with imem_ready=1: next state KILL.
REQ-030 Redirect in WAIT without imem_rvalid: next state KILL.
REQ-031 Redirect in WAIT with imem_rvalid: data discarded; next state REQ.
REQ-032 Redirect in HOLD or BOOT: next state REQ.
REQ-033 KILL: imem_req=0; the next imem_rvalid is dropped, then next state REQ; a further redirect in KILL only updates pc.
REQ-034 pc+4 wraps 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-035 Response latency: imem_rvalid to fetch_valid is 1 cycle. Fetch throughput with zero-wait memory is 1 instruction per 2 cycles.

Reset
REQ-036 While rst_n=0: state=BOOT, pc=RESET_PC, fetch_valid=0, fetch_instr=0, fetch_pc=RESET_PC, misalign=0, imem_req=0.
REQ-037 Reset asserted mid-transaction abandons the transaction; after release, an imem_rvalid arriving without an outstanding request is ignored.

Structure
REQ-038 A shared package holds the state encoding (3-bit enum), RESET_PC default and the word-alignment mask.
REQ-039 Sub-module: one, pc_redirect_arb (combinational priority select, alignment and misalign generation); all state lives in pc_sequencer.

Verification
REQ-040 Reset release with zero-wait memory -> imem_addr sequence 3000, 3004, 3008; fetch_valid 1 cycle after each rvalid; fetch_pc_4=fetch_pc+4.
REQ-041 stall=1 for 5 cycles while the buffer holds 3004 -> fetch_instr and fetch_pc stable, no imem_req in HOLD; fetch resumes at 3008 after release.
REQ-042 id_redir to 0x4000 in WAIT, rvalid 3 cycles later -> that response dropped (KILL); next imem_addr=0x4000; fetch_valid=0 throughout.
REQ-043 exc_redir to 0x4180 and id_redir to 0x5000 in the same cycle -> pc=0x4180, misalign=0.
REQ-044 id_target=0x4002 -> imem_addr=0x4000, misalign high for exactly one cycle.
REQ-045 pc=0xFFFF_FFFC with a fetch completing -> next imem_addr=0x0000_0000; rst_n pulsed low mid-WAIT -> outputs at reset values immediately, and the stale rvalid is ignored.
